mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-client arbiter in front of the byte-serial memory controller. It accepts word fetches from the instruction-fetch unit and load/store requests from the load/store buffer, and presents exactly one request at a time on the controller's request bus. It holds that request stable until the controller signals completion, then returns the result to the owning client with a one-cycle done pulse. It also supports discarding an in-flight instruction fetch on pipeline flush.

## Interface
Parameters: none.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-low
- rdy_in  in  1  global enable; when low, all state holds
- clear_in  in  1  flush; abandons any pending or in-flight ifetch
- if_valid  in  1  ifetch request; held until if_done
- if_addr  in  32  ifetch byte address
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle
- if_data  out  32  fetched word
- ls_valid  in  1  load/store request; held until ls_done
- ls_wr  in  1  1 = store
- ls_len  in  3  [1:0] encodes 0 = 1 B, 1 = 2 B, 2 = 4 B; [2] = sign-extend on load
- ls_addr  in  32  byte address
- ls_value  in  32  store data
- ls_done  out  1  one-cycle pulse; ls_data valid in the same cycle
- ls_data  out  32  load result; 0 for stores
- mc_wating  out  1  request present to the memory controller
- mc_wr, mc_len, mc_addr, mc_value  out  1/3/32/32  request fields to the memory controller
- mc_ready  in  1  controller finished the presented request
- mc_result  in  32  controller read result, valid while mc_ready is high

## Operation
- All outputs are registered.
- States:
  - IDLE
  - BUSY_IF
  - BUSY_LS
  - DRAIN: ifetch in flight whose result is to be discarded
- IDLE behaviour:
  - A client whose done output is high this cycle is treated as not valid.
  - if_valid is also ignored while clear_in is high.
  - If any eligible request is present, the arbiter latches it into the mc_* registers, sets mc_wating to 1, and moves to BUSY_IF or BUSY_LS.
  - An ifetch request is driven as mc_wr=0, mc_len=3'b010, mc_value=0.
- BUSY_x:
  - mc_* stay constant.
  - On mc_ready=1, the arbiter captures mc_result into x_data (ls_data is 0 for stores), pulses x_done, clears mc_wating, and returns to IDLE.
  - A mandatory one-cycle turnaround with mc_wating=0 follows every completion.
- clear_in behaviour:
  - clear_in in BUSY_IF without mc_ready moves to DRAIN.
  - clear_in in BUSY_IF together with mc_ready goes to IDLE with no if_done pulse.
  - DRAIN holds mc_wating until mc_ready, then goes to IDLE with no if_done pulse and if_data unchanged.
  - clear_in never affects BUSY_LS, so stores are never dropped.
- Both clients valid in IDLE: the grant follows the policy in Configuration.
- rst_in=0 at a clock edge forces the following, regardless of state or an in-flight controller operation:
  - state IDLE
  - mc_wating, mc_wr, if_done, ls_done = 0
  - mc_len, mc_addr, mc_value, if_data, ls_data = 0
  - round-robin pointer set to favour ifetch

## Timing
- Request to mc_wating: 1 cycle, since the request is sampled at an IDLE edge.
- The done pulse is asserted the cycle after mc_ready is sampled high.
- Total latency is 1 + controller latency + 1 cycles.
- The earliest re-grant is the cycle after a done pulse, which gives back-to-back throughput of one request every controller latency + 2 cycles.
- if_done and ls_done are never high in the same cycle.
- A done output is high for exactly one cycle, except that it holds while rdy_in=0.
- rdy_in=0 freezes every register, including done pulses, the state and the pointer.

## Configuration
- MEM_ARB_RR_EN defined: round-robin grant.
  - A 1-bit pointer records the last granted client.
  - On contention, the other client wins.
  - The pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority; ls always wins contention, and no pointer exists.

## Test plan
- Single fetch: if_valid=1, if_addr=0x100, controller returns 0xDEADBEEF.
  - mc_* show wr=0, len=2, addr=0x100 from the next cycle.
  - if_done pulses once with if_data=0xDEADBEEF, and mc_wating is low the following cycle.
- Signed byte load: ls_len=3'b100, ls_addr=0x203, mc_result=0xFFFFFF80 -> ls_done with ls_data=0xFFFFFF80, mc_len=3'b100 held throughout.
- Store: ls_wr=1, len=2, addr=0x3000, value=0x12345678 -> mc_* hold those values until mc_ready, ls_done pulses with ls_data=0, and no if_done.
- Contention, both clients valid in IDLE:
  - With MEM_ARB_RR_EN and reset pointer: ifetch is granted first, then ls.
  - Without MEM_ARB_RR_EN: ls is granted first, and ifetch is granted on the turnaround-plus-one cycle.
- Flush: clear_in pulses 2 cycles after the ifetch grant -> mc_wating stays high until mc_ready, no if_done, IDLE after.
  - Flush in the same cycle as ls in flight -> ls_done still pulses.
- Stall/reset: rdy_in=0 for 5 cycles while ls_done is high -> ls_done stays high, then falls 1 cycle after rdy_in returns.
  - rst_in=0 mid-BUSY_LS -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client (ifetch, load/store) arbiter in front of the byte-serial memory controller
// Build option MEM_ARB_RR_EN: round-robin grant on contention; undefined gives load/store fixed priority.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_valid,
  input  logic        ls_wr,
  input  logic [2:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_value,
  output logic        ls_done,
  output logic [31:0] ls_data,
  output logic        mc_wating,
  output logic        mc_wr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_value,
  input  logic        mc_ready,
  input  logic [31:0] mc_result
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DRAIN} state_t;

  state_t      state, state_next;
  logic        if_done_next, ls_done_next, mc_wating_next, mc_wr_next;
  logic [2:0]  mc_len_next;
  logic [31:0] if_data_next, ls_data_next, mc_addr_next, mc_value_next;
  logic        if_elig, ls_elig, grant_ls, grant_if;

`ifdef MEM_ARB_RR_EN
  logic last_ls, last_ls_next;
`endif

  // A client still showing its done pulse has not had a chance to drop valid yet
  assign if_elig = if_valid && !if_done && !clear_in;
  assign ls_elig = ls_valid && !ls_done;
`ifdef MEM_ARB_RR_EN
  assign grant_ls = ls_elig && (!if_elig || !last_ls);
`else
  assign grant_ls = ls_elig;
`endif
  assign grant_if = if_elig && !grant_ls;

  always_comb begin
    state_next     = state;
    if_done_next   = 1'b0;
    ls_done_next   = 1'b0;
    if_data_next   = if_data;
    ls_data_next   = ls_data;
    mc_wating_next = mc_wating;
    mc_wr_next     = mc_wr;
    mc_len_next    = mc_len;
    mc_addr_next   = mc_addr;
    mc_value_next  = mc_value;
`ifdef MEM_ARB_RR_EN
    last_ls_next   = last_ls;
`endif
    case (state)
      IDLE: begin
        if (grant_ls) begin
          mc_wating_next = 1'b1;
          mc_wr_next     = ls_wr;
          mc_len_next    = ls_len;
          mc_addr_next   = ls_addr;
          mc_value_next  = ls_value;
          state_next     = BUSY_LS;
`ifdef MEM_ARB_RR_EN
          last_ls_next   = 1'b1;
`endif
        end else if (grant_if) begin
          mc_wating_next = 1'b1;
          mc_wr_next     = 1'b0;
          mc_len_next    = 3'b010;
          mc_addr_next   = if_addr;
          mc_value_next  = 32'h0;
          state_next     = BUSY_IF;
`ifdef MEM_ARB_RR_EN
          last_ls_next   = 1'b0;
`endif
        end
      end
      BUSY_IF: begin
        if (mc_ready) begin
          mc_wating_next = 1'b0;
          state_next     = IDLE;
          if (!clear_in) begin
            if_done_next = 1'b1;
            if_data_next = mc_result;
          end
        end else if (clear_in) begin
          state_next = DRAIN;
        end
      end
      BUSY_LS: begin
        if (mc_ready) begin
          mc_wating_next = 1'b0;
          ls_done_next   = 1'b1;
          ls_data_next   = mc_wr ? 32'h0 : mc_result;
          state_next     = IDLE;
        end
      end
      DRAIN: begin
        // Controller cannot abort, so wait out the flushed fetch and drop its result
        if (mc_ready) begin
          mc_wating_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_data   <= 32'h0;
      ls_data   <= 32'h0;
      mc_wating <= 1'b0;
      mc_wr     <= 1'b0;
      mc_len    <= 3'b000;
      mc_addr   <= 32'h0;
      mc_value  <= 32'h0;
`ifdef MEM_ARB_RR_EN
      last_ls   <= 1'b1;
`endif
    end else if (rdy_in) begin
      state     <= state_next;
      if_done   <= if_done_next;
      ls_done   <= ls_done_next;
      if_data   <= if_data_next;
      ls_data   <= ls_data_next;
      mc_wating <= mc_wating_next;
      mc_wr     <= mc_wr_next;
      mc_len    <= mc_len_next;
      mc_addr   <= mc_addr_next;
      mc_value  <= mc_value_next;
`ifdef MEM_ARB_RR_EN
      last_ls   <= last_ls_next;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (request and done scoreboards, controller model)
// Expectations for contention follow MEM_ARB_RR_EN when it is defined for the bench.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        if_valid, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_valid, ls_wr, ls_done;
  logic [2:0]  ls_len;
  logic [31:0] ls_addr, ls_value, ls_data;
  logic        mc_wating, mc_wr;
  logic [2:0]  mc_len;
  logic [31:0] mc_addr, mc_value;
  logic        mc_ready = 1'b0;
  logic [31:0] mc_result = 32'h0;

  localparam logic [31:0] KEY = 32'h0F0F_0000;

  typedef struct packed {logic wr; logic [2:0] len; logic [31:0] addr; logic [31:0] value;} req_t;
  typedef struct packed {logic ls; logic [31:0] data;} done_t;
  typedef struct {
    logic ls; logic wr; logic [2:0] len;
    logic [31:0] addr; logic [31:0] value; logic [31:0] result;
    int lat; logic [31:0] exp_data;
  } vec_t;

  req_t  req_q[$];
  done_t done_q[$];
  vec_t  vec[6];
  int    n_cmp = 0, n_bad = 0;
  int    if_pulses = 0, ls_pulses = 0;
  int    ctl_lat = 0, ctl_cnt = 0;
  logic  ctl_by_addr = 1'b0;
  logic [31:0] ctl_result = 32'h0;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_value(ls_value), .ls_done(ls_done), .ls_data(ls_data),
    .mc_wating(mc_wating), .mc_wr(mc_wr), .mc_len(mc_len), .mc_addr(mc_addr),
    .mc_value(mc_value), .mc_ready(mc_ready), .mc_result(mc_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_req(input string name, input req_t act, input req_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got wr=%0b len=%0h addr=%h value=%h expected wr=%0b len=%0h addr=%h value=%h",
               name, act.wr, act.len, act.addr, act.value, exp.wr, exp.len, exp.addr, exp.value);
    end
  endtask

  // Controller model: ready for one cycle after ctl_lat waiting cycles; result garbage otherwise
  always @(negedge clk_in) begin
    if (!rst_in || !mc_wating || mc_ready) begin
      mc_ready  = 1'b0;
      mc_result = 32'hBAD0_BAD0;
      ctl_cnt   = 0;
    end else if (rdy_in) begin
      if (ctl_cnt >= ctl_lat) begin
        mc_ready  = 1'b1;
        mc_result = ctl_by_addr ? (mc_addr ^ KEY) : ctl_result;
      end else begin
        ctl_cnt++;
      end
    end
  end

  // Scoreboard side: pop on new done pulses and on new requests to the controller
  logic prev_wating = 1'b0;
  req_t req_snap;
  always @(posedge clk_in) begin
    #2;
    if (rdy_in) begin
      if (if_done || ls_done) begin
        check("done_exclusive", 32'(if_done & ls_done), 32'h0);
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: if_done=%0b ls_done=%0b expected no done", if_done, ls_done);
        end else begin
          done_t e;
          e = done_q.pop_front();
          check("done_client", 32'(ls_done), 32'(e.ls));
          check("done_data", ls_done ? ls_data : if_data, e.data);
        end
        if (if_done) if_pulses++;
        if (ls_done) ls_pulses++;
      end
      if (mc_wating && !prev_wating) begin
        req_snap = {mc_wr, mc_len, mc_addr, mc_value};
        if (req_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_request: addr=%h expected no request", mc_addr);
        end else begin
          check_req("mc_request", req_snap, req_q.pop_front());
        end
      end else if (mc_wating) begin
        check_req("mc_hold", {mc_wr, mc_len, mc_addr, mc_value}, req_snap);
      end
      prev_wating = mc_wating;
    end
  end

  task automatic expect_done(input logic ls, input logic [31:0] data);
    done_t d;
    d.ls = ls; d.data = data;
    done_q.push_back(d);
  endtask

  task automatic drive_if(input logic [31:0] a);
    req_t r;
    if_valid = 1'b1; if_addr = a;
    r.wr = 1'b0; r.len = 3'b010; r.addr = a; r.value = 32'h0;
    req_q.push_back(r);
  endtask

  task automatic drive_ls(input logic wr, input logic [2:0] len, input logic [31:0] a, input logic [31:0] v);
    req_t r;
    ls_valid = 1'b1; ls_wr = wr; ls_len = len; ls_addr = a; ls_value = v;
    r.wr = wr; r.len = len; r.addr = a; r.value = v;
    req_q.push_back(r);
  endtask

  task automatic do_reset();
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; if_valid = 1'b0; ls_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  // Waits for 'want' done pulses, dropping each client's valid when it sees its done
  task automatic wait_dones(input int want, input int budget, output int first_cyc, output int last_cyc);
    int seen = 0;
    int cyc = 0;
    first_cyc = -1; last_cyc = -1;
    while (seen < want && cyc < budget) begin
      @(negedge clk_in);
      cyc++;
      if (if_done || ls_done) begin
        seen++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (if_done) if_valid = 1'b0;
        if (ls_done) ls_valid = 1'b0;
      end
    end
    if (seen < want) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_dones_timeout: saw %0d done pulses expected %0d", seen, want);
    end
  endtask

  task automatic single(input string tag, input logic ls, input logic wr, input logic [2:0] len,
                        input logic [31:0] a, input logic [31:0] v, input logic [31:0] result,
                        input int lat, input logic [31:0] exp_data);
    int f, l;
    ctl_lat = lat; ctl_result = result;
    if (ls) drive_ls(wr, len, a, v);
    else    drive_if(a);
    expect_done(ls, exp_data);
    wait_dones(1, 40, f, l);
    check({tag, "_latency"}, 32'(l), 32'(lat + 2));
    check({tag, "_turnaround"}, 32'(mc_wating), 32'h0);
    @(negedge clk_in);
    check({tag, "_single_pulse"}, 32'({if_done, ls_done}), 32'h0);
  endtask

  task automatic contend(input string tag, input logic ls_first, input logic [31:0] ia, input logic [31:0] la);
    int f, l;
    ctl_by_addr = 1'b1; ctl_lat = 1;
    if (ls_first) begin
      drive_ls(1'b0, 3'b010, la, 32'h0); drive_if(ia);
      expect_done(1'b1, la ^ KEY); expect_done(1'b0, ia ^ KEY);
    end else begin
      drive_if(ia); drive_ls(1'b0, 3'b010, la, 32'h0);
      expect_done(1'b0, ia ^ KEY); expect_done(1'b1, la ^ KEY);
    end
    wait_dones(2, 40, f, l);
    check({tag, "_first_latency"}, 32'(f), 32'd3);
    check({tag, "_regrant_gap"}, 32'(l - f), 32'd3);
    @(negedge clk_in);
    ctl_by_addr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ip, lp;
    logic [31:0] held;
    if_addr = 32'h0; ls_wr = 1'b0; ls_len = 3'b000; ls_addr = 32'h0; ls_value = 32'h0;

    vec[0] = '{1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
    vec[1] = '{1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'hFFFF_FF80, 1, 32'hFFFF_FF80};
    vec[2] = '{1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h1234_5678, 32'hAAAA_5555, 3, 32'h0};
    vec[3] = '{1'b1, 1'b0, 3'b001, 32'h0000_0040, 32'h0, 32'h0000_BEEF, 0, 32'h0000_BEEF};
    vec[4] = '{1'b0, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0000_0013, 0, 32'h0000_0013};
    vec[5] = '{1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 4, 32'hCAFE_F00D};

    do_reset();
    check("reset_mc_wating", 32'(mc_wating), 32'h0);
    check("reset_done", 32'({if_done, ls_done}), 32'h0);
    check("reset_mc_fields", {28'h0, mc_wr, mc_len} | mc_addr | mc_value, 32'h0);

    for (int i = 0; i < 6; i++)
      single($sformatf("vec%0d", i), vec[i].ls, vec[i].wr, vec[i].len, vec[i].addr,
             vec[i].value, vec[i].result, vec[i].lat, vec[i].exp_data);

    // Contention from reset pointer, then after a lone fetch the ls side must win
    do_reset();
`ifdef MEM_ARB_RR_EN
    contend("contend_reset", 1'b0, 32'h400, 32'h800);
`else
    contend("contend_reset", 1'b1, 32'h400, 32'h800);
`endif
    single("lone_fetch", 1'b0, 1'b0, 3'b010, 32'h440, 32'h0, 32'h7777_0001, 0, 32'h7777_0001);
    contend("contend_after_if", 1'b1, 32'h480, 32'h880);

    // Flush two cycles after the fetch grant: result drained and dropped
    ctl_lat = 5; ctl_result = 32'h5555_AAAA;
    held = if_data; ip = if_pulses;
    drive_if(32'h500);
    repeat (2) @(negedge clk_in);
    clear_in = 1'b1; if_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      clear_in = 1'b0;
      check("flush_hold_wating", 32'(mc_wating), 32'h1);
    end
    @(negedge clk_in);
    check("flush_release_wating", 32'(mc_wating), 32'h0);
    repeat (2) @(negedge clk_in);
    check("flush_no_if_done", 32'(if_pulses), 32'(ip));
    check("flush_if_data_kept", if_data, held);
    single("after_flush", 1'b1, 1'b0, 3'b010, 32'h540, 32'h0, 32'h0102_0304, 0, 32'h0102_0304);

    // Flush coinciding with mc_ready: straight to idle, no done
    ctl_lat = 0; ctl_result = 32'h9999_0000;
    ip = if_pulses;
    drive_if(32'h600);
    @(negedge clk_in);
    clear_in = 1'b1; if_valid = 1'b0;
    @(negedge clk_in);
    clear_in = 1'b0;
    check("flush_ready_wating", 32'(mc_wating), 32'h0);
    check("flush_ready_if_done", 32'(if_done), 32'h0);
    @(negedge clk_in);
    check("flush_ready_no_pulse", 32'(if_pulses), 32'(ip));
    check("flush_ready_if_data", if_data, held);

    // Flush while a load is in flight must not drop it
    ctl_lat = 3; ctl_result = 32'h0BAD_CAFE;
    lp = ls_pulses;
    drive_ls(1'b0, 3'b010, 32'h700, 32'h0);
    expect_done(1'b1, 32'h0BAD_CAFE);
    @(negedge clk_in);
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    begin
      int f, l;
      wait_dones(1, 40, f, l);
    end
    @(negedge clk_in);
    check("flush_ls_kept", 32'(ls_pulses), 32'(lp + 1));

    // Stall with ls_done high: pulse holds until rdy_in returns
    ctl_lat = 1; ctl_result = 32'h1122_3344;
    drive_ls(1'b0, 3'b010, 32'h900, 32'h0);
    expect_done(1'b1, 32'h1122_3344);
    begin
      int f, l;
      wait_dones(1, 40, f, l);
    end
    rdy_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check("stall_ls_done_held", 32'(ls_done), 32'h1);
      check("stall_ls_data_held", ls_data, 32'h1122_3344);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("stall_ls_done_fall", 32'(ls_done), 32'h0);

    // Reset in the middle of a store
    ctl_lat = 10;
    drive_ls(1'b1, 3'b010, 32'hA00, 32'hFEED_FACE);
    expect_done(1'b1, 32'h0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0; ls_valid = 1'b0;
    @(negedge clk_in);
    check("rst_mc_wating", 32'(mc_wating), 32'h0);
    check("rst_mc_wr", 32'(mc_wr), 32'h0);
    check("rst_mc_len", 32'(mc_len), 32'h0);
    check("rst_mc_addr", mc_addr, 32'h0);
    check("rst_mc_value", mc_value, 32'h0);
    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_ls_done", 32'(ls_done), 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_data", ls_data, 32'h0);
    done_q.delete();
    rst_in = 1'b1;
    single("post_reset", 1'b0, 1'b0, 3'b010, 32'hB00, 32'h0, 32'h600D_F00D, 1, 32'h600D_F00D);

    repeat (2) @(negedge clk_in);
    check("done_queue_drained", 32'(done_q.size()), 32'h0);
    check("req_queue_drained", 32'(req_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
